// File: rtl/uart_alu_pkg.sv
// Shared definitions for the UART-ALU system: opcodes, FSM state encoding, opcode width.
// Latency: none (definitions only).
// Backpressure: not applicable.
package uart_alu_pkg;

  // Opcode width used by this stage and by the ALU.
  localparam int NB_OP_DEFAULT = 6;

  // Legal ALU opcodes (low bits of the opcode byte).
  localparam logic [NB_OP_DEFAULT-1:0] OP_ADD = 6'h20;
  localparam logic [NB_OP_DEFAULT-1:0] OP_SUB = 6'h22;
  localparam logic [NB_OP_DEFAULT-1:0] OP_AND = 6'h24;
  localparam logic [NB_OP_DEFAULT-1:0] OP_OR  = 6'h25;
  localparam logic [NB_OP_DEFAULT-1:0] OP_XOR = 6'h26;
  localparam logic [NB_OP_DEFAULT-1:0] OP_NOR = 6'h27;
  localparam logic [NB_OP_DEFAULT-1:0] OP_SRA = 6'h03;
  localparam logic [NB_OP_DEFAULT-1:0] OP_SRL = 6'h02;

  // Frame sequencer states of uart_alu_if.
  typedef enum logic [2:0] {
    WAIT_A  = 3'd0,
    WAIT_B  = 3'd1,
    WAIT_OP = 3'd2,
    EXEC    = 3'd3,
    SEND    = 3'd4,
    WAIT_TX = 3'd5
  } state_t;

endpackage

// File: rtl/uart_if_timer.sv
// Inter-byte timeout counter: counts while run=1, clears on clr or when idle, flags terminal count.
// Latency: tc is combinational from the count; it rises TIMEOUT_CYCLES-1 cycles after the last clear.
// Backpressure: none; the owner must clear the counter when it reacts to tc.
// Ports: clk, rst_n (sync active-low), run (count enable), clr (force to zero), tc (count == TIMEOUT_CYCLES-1).
module uart_if_timer #(
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic clr,
  output logic tc
);

  localparam int NB_CNT = $clog2(TIMEOUT_CYCLES);
  localparam logic [NB_CNT-1:0] TC_VAL = NB_CNT'(TIMEOUT_CYCLES - 1);

  logic [NB_CNT-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n || clr || !run) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + NB_CNT'(1);
    end
  end

  assign tc = run && (cnt == TC_VAL);

endmodule

// File: rtl/uart_alu_if.sv
// Frames received bytes (A, B, opcode) for the ALU and hands the captured result to uart_tx.
// Latency: o_tx_start is high during the 2nd cycle after the edge that samples the opcode byte.
// Backpressure: none upstream; bytes arriving while a result is pending (EXEC/SEND/WAIT_TX) are dropped.
// Ports: clk, i_rst_n (sync active-low); i_rx_data/i_rx_done from uart_rx; i_alu_result from the ALU;
//        i_tx_done from uart_tx; o_alu_a/o_alu_b/o_alu_op to the ALU; o_tx_data/o_tx_start to uart_tx;
//        o_error pulses on an illegal opcode (or inter-byte timeout when UART_ALU_IF_TIMEOUT_EN is defined).
module uart_alu_if
  import uart_alu_pkg::*;
#(
  parameter int NB_DATA = 8,
  parameter int NB_OP   = NB_OP_DEFAULT
`ifdef UART_ALU_IF_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 1_000_000
`endif
) (
  input  logic               clk,
  input  logic               i_rst_n,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic               i_rx_done,
  input  logic [NB_DATA-1:0] i_alu_result,
  input  logic               i_tx_done,
  output logic [NB_DATA-1:0] o_alu_a,
  output logic [NB_DATA-1:0] o_alu_b,
  output logic [NB_OP-1:0]   o_alu_op,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic               o_tx_start,
  output logic               o_error
);

  state_t state, next_state;
  logic   op_legal;
  logic   timeout_hit;

  // Opcode byte is legal only with its upper bits clear and a known low-bit code.
  always_comb begin
    op_legal = 1'b0;
    if (i_rx_data[NB_DATA-1:NB_OP] == '0) begin
      case (i_rx_data[NB_OP-1:0])
        NB_OP'(OP_ADD), NB_OP'(OP_SUB), NB_OP'(OP_AND), NB_OP'(OP_OR),
        NB_OP'(OP_XOR), NB_OP'(OP_NOR), NB_OP'(OP_SRA), NB_OP'(OP_SRL): op_legal = 1'b1;
        default: op_legal = 1'b0;
      endcase
    end
  end

`ifdef UART_ALU_IF_TIMEOUT_EN
  logic tmr_tc;

  // Count only while a frame is partially received; restart on each byte or state move.
  uart_if_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timer (
    .clk   (clk),
    .rst_n (i_rst_n),
    .run   ((state == WAIT_B) || (state == WAIT_OP)),
    .clr   (i_rx_done || (next_state != state)),
    .tc    (tmr_tc)
  );

  // A byte arriving on the terminal cycle wins over the timeout.
  assign timeout_hit = tmr_tc && !i_rx_done;
`else
  assign timeout_hit = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      state <= WAIT_A;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      WAIT_A:  if (i_rx_done) next_state = WAIT_B;
      WAIT_B: begin
        if (i_rx_done)        next_state = WAIT_OP;
        else if (timeout_hit) next_state = WAIT_A;
      end
      WAIT_OP: begin
        if (i_rx_done)        next_state = op_legal ? EXEC : WAIT_A;
        else if (timeout_hit) next_state = WAIT_A;
      end
      EXEC:    next_state = SEND;
      SEND:    next_state = WAIT_TX;
      // A byte coinciding with tx_done is not taken as operand A.
      WAIT_TX: if (i_tx_done) next_state = WAIT_A;
      default: next_state = WAIT_A;
    endcase
  end

  // Moore output: start request for the single SEND cycle.
  always_comb begin
    o_tx_start = (state == SEND);
  end

  // Datapath registers: plain loads qualified by state and the received-byte strobe.
  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      o_alu_a   <= '0;
      o_alu_b   <= '0;
      o_alu_op  <= '0;
      o_tx_data <= '0;
      o_error   <= 1'b0;
    end else begin
      if ((state == WAIT_A) && i_rx_done) o_alu_a <= i_rx_data;
      if ((state == WAIT_B) && i_rx_done) o_alu_b <= i_rx_data;
      if ((state == WAIT_OP) && i_rx_done && op_legal) o_alu_op <= i_rx_data[NB_OP-1:0];
      // ALU inputs have settled for a full cycle by the time EXEC samples the result.
      if (state == EXEC) o_tx_data <= i_alu_result;
      o_error <= ((state == WAIT_OP) && i_rx_done && !op_legal) || timeout_hit;
    end
  end

endmodule
